// File: rtl/textwr_pkg.sv
// textwr_pkg: ASCII codes and state encoding shared by the text writer
package textwr_pkg;
  localparam logic [7:0] ASC_BS       = 8'h08;
  localparam logic [7:0] ASC_TAB      = 8'h09;
  localparam logic [7:0] ASC_LF       = 8'h0A;
  localparam logic [7:0] ASC_FF       = 8'h0C;
  localparam logic [7:0] ASC_CR       = 8'h0D;
  localparam logic [7:0] ASC_SPACE    = 8'h20;
  localparam logic [7:0] ASC_PRINT_LO = 8'h20;
  localparam logic [7:0] ASC_PRINT_HI = 8'h7E;
  typedef enum logic [1:0] {CLR_ALL, IDLE, CLR_ROW} state_t;
endpackage

// File: rtl/textbuf_writer.sv
// textbuf_writer: UART byte stream to row/column text RAM writes with cursor and circular scroll
// Optional: define TEXTWR_BS_ERASE_EN to make backspace blank the character it steps back over.
module textbuf_writer import textwr_pkg::*; #(
  parameter int COLS  = 160,
  parameter int ROWS  = 64,
  parameter int COL_W = 8,
  parameter int ROW_W = 6,
  parameter int TAB_W = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [7:0]             in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic                   wr_en,
  output logic [ROW_W+COL_W-1:0] wr_addr,
  output logic [7:0]             wr_data,
  output logic [ROW_W-1:0]       scroll_row,
  output logic [ROW_W-1:0]       cursor_row,
  output logic [COL_W-1:0]       cursor_col
);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);
  localparam logic [COL_W-1:0] TAB_MASK = COL_W'(TAB_W - 1);
  state_t                   state, state_n;
  logic [ROW_W-1:0]         clr_row, clr_row_n, scroll_n, crow_n, row_inc;
  logic [COL_W-1:0]         clr_col, clr_col_n, ccol_n;
  logic [ROW_W+COL_W-1:0]   wr_addr_n;
  logic [7:0]               wr_data_n;
  logic [COL_W:0]           tab_n;
  logic                     clr_fin, clr_fin_n, in_ready_n, wr_en_n, last, nl;
  // Next-state: clear sequencing (shared row/col counter, clr_fin marks the idle-return cycle) and byte interpretation
  always_comb begin
    state_n    = state;
    clr_row_n  = clr_row;
    clr_col_n  = clr_col;
    clr_fin_n  = clr_fin;
    in_ready_n = in_ready;
    wr_en_n    = 1'b0;
    wr_addr_n  = wr_addr;
    wr_data_n  = wr_data;
    scroll_n   = scroll_row;
    crow_n     = cursor_row;
    ccol_n     = cursor_col;
    row_inc    = cursor_row + 1'b1;
    tab_n      = {1'b0, cursor_col | TAB_MASK} + 1'b1;
    last       = clr_col == COL_LAST && (state == CLR_ROW || clr_row == ROW_LAST);
    nl         = 1'b0;
    if (state != IDLE) begin
      if (clr_fin) begin
        state_n    = IDLE;
        in_ready_n = 1'b1;
      end else begin
        wr_en_n   = 1'b1;
        wr_addr_n = {clr_row, clr_col};
        wr_data_n = ASC_SPACE;
        clr_col_n = clr_col == COL_LAST ? '0 : clr_col + 1'b1;
        clr_row_n = clr_col == COL_LAST ? clr_row + 1'b1 : clr_row;
        clr_fin_n = last;
      end
    end else if (in_valid && in_ready) begin
      if (in_data >= ASC_PRINT_LO && in_data <= ASC_PRINT_HI) begin
        wr_en_n   = 1'b1;
        wr_addr_n = {cursor_row, cursor_col};
        wr_data_n = in_data;
        ccol_n    = cursor_col + 1'b1;
        nl        = cursor_col == COL_LAST;
      end else if (in_data == ASC_CR) begin
        ccol_n = '0;
      end else if (in_data == ASC_LF) begin
        nl = 1'b1;
      end else if (in_data == ASC_BS) begin
        if (cursor_col != '0) begin
          ccol_n = cursor_col - 1'b1;
`ifdef TEXTWR_BS_ERASE_EN
          wr_en_n   = 1'b1;
          wr_addr_n = {cursor_row, ccol_n};
          wr_data_n = ASC_SPACE;
`endif
        end
      end else if (in_data == ASC_TAB) begin
        ccol_n = tab_n > {1'b0, COL_LAST} ? COL_LAST : tab_n[COL_W-1:0];
      end else if (in_data == ASC_FF) begin
        ccol_n     = '0;
        crow_n     = '0;
        scroll_n   = '0;
        state_n    = CLR_ALL;
        clr_row_n  = '0;
        clr_col_n  = '0;
        clr_fin_n  = 1'b0;
        in_ready_n = 1'b0;
      end
      if (nl) begin
        ccol_n     = '0;
        crow_n     = row_inc;
        scroll_n   = row_inc == scroll_row ? scroll_row + 1'b1 : scroll_row;
        state_n    = CLR_ROW;
        clr_row_n  = row_inc;
        clr_col_n  = '0;
        clr_fin_n  = 1'b0;
        in_ready_n = 1'b0;
      end
    end
  end
  // State and output registers; reset restarts the full-screen clear from address 0
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= CLR_ALL;
      clr_row    <= '0;
      clr_col    <= '0;
      clr_fin    <= 1'b0;
      in_ready   <= 1'b0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= ASC_SPACE;
      scroll_row <= '0;
      cursor_row <= '0;
      cursor_col <= '0;
    end else begin
      state      <= state_n;
      clr_row    <= clr_row_n;
      clr_col    <= clr_col_n;
      clr_fin    <= clr_fin_n;
      in_ready   <= in_ready_n;
      wr_en      <= wr_en_n;
      wr_addr    <= wr_addr_n;
      wr_data    <= wr_data_n;
      scroll_row <= scroll_n;
      cursor_row <= crow_n;
      cursor_col <= ccol_n;
    end
  end
endmodule

// File: tb/tb_textbuf_writer.sv
// tb_textbuf_writer: scoreboarded random and directed bench for textbuf_writer
module tb_textbuf_writer;
  localparam int COLS = 160, ROWS = 64, COL_W = 8, ROW_W = 6, TAB_W = 8;
`ifdef TEXTWR_BS_ERASE_EN
  localparam bit ERASE = 1'b1;
`else
  localparam bit ERASE = 1'b0;
`endif
  logic clk = 1'b0, reset = 1'b1, in_valid = 1'b0, in_ready, wr_en;
  logic [7:0] in_data = 8'h00, wr_data;
  logic [ROW_W+COL_W-1:0] wr_addr;
  logic [ROW_W-1:0] scroll_row, cursor_row;
  logic [COL_W-1:0] cursor_col;
  logic [21:0] exp_q[$];
  logic [21:0] got, want;
  int tests = 0, fails = 0;
  int m_row, m_col, m_scroll;

  textbuf_writer #(.COLS(COLS), .ROWS(ROWS), .COL_W(COL_W), .ROW_W(ROW_W), .TAB_W(TAB_W)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .scroll_row(scroll_row),
    .cursor_row(cursor_row), .cursor_col(cursor_col));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic summary_and_finish();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  endtask

  task automatic timeout(input string nm);
    fails++;
    $display("FAIL %s: timed out waiting for in_ready", nm);
    summary_and_finish();
  endtask

  // Monitor: every RAM write must match the oldest expected write
  always @(negedge clk) begin
    if (!reset && wr_en) begin
      got = {wr_addr, wr_data};
      if (exp_q.size() == 0) chk("unexpected_write", got, 22'h3fffff ^ got);
      else begin
        want = exp_q.pop_front();
        chk("write", got, want);
      end
    end
  end

  task automatic push(input int r, input int c, input logic [7:0] d);
    exp_q.push_back({6'(r), 8'(c), d});
  endtask

  task automatic push_clear_row(input int r);
    for (int c = 0; c < COLS; c++) push(r, c, 8'h20);
  endtask

  task automatic push_clear_all();
    for (int r = 0; r < ROWS; r++) push_clear_row(r);
  endtask

  task automatic model_newline();
    m_col = 0;
    m_row = (m_row + 1) % ROWS;
    if (m_row == m_scroll) m_scroll = (m_scroll + 1) % ROWS;
    push_clear_row(m_row);
  endtask

  // Reference model of the terminal rules, in plain integer terms
  task automatic model_byte(input logic [7:0] b);
    if (b >= 8'h20 && b <= 8'h7E) begin
      push(m_row, m_col, b);
      if (m_col == COLS - 1) model_newline();
      else m_col++;
    end else if (b == 8'h0D) m_col = 0;
    else if (b == 8'h0A) model_newline();
    else if (b == 8'h08) begin
      if (m_col > 0) begin
        m_col--;
        if (ERASE) push(m_row, m_col, 8'h20);
      end
    end else if (b == 8'h09) begin
      m_col = (m_col / TAB_W + 1) * TAB_W;
      if (m_col > COLS - 1) m_col = COLS - 1;
    end else if (b == 8'h0C) begin
      m_row = 0; m_col = 0; m_scroll = 0;
      push_clear_all();
    end
  endtask

  task automatic send(input logic [7:0] b);
    int n = 0;
    while (!in_ready) begin
      @(negedge clk);
      if (++n > 20000) timeout("send_wait");
    end
    in_data = b;
    in_valid = 1'b1;
    model_byte(b);
    @(negedge clk);
    in_valid = 1'b0;
    if (b >= 8'h20 && b <= 8'h7E) chk("wr_pulse", wr_en, 1);
    chk("cursor_row", cursor_row, m_row);
    chk("cursor_col", cursor_col, m_col);
    chk("scroll_row", scroll_row, m_scroll);
  endtask

  task automatic wait_low(input string nm, input int exp);
    int n = 0;
    while (!in_ready) begin
      n++;
      @(negedge clk);
      if (n > 20000) timeout(nm);
    end
    chk(nm, n, exp);
  endtask

  task automatic do_reset();
    int n = 0;
    reset = 1'b1;
    in_valid = 1'b0;
    exp_q.delete();
    m_row = 0; m_col = 0; m_scroll = 0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 8'h20);
    chk("rst_cursor", {cursor_row, cursor_col}, 0);
    chk("rst_scroll", scroll_row, 0);
    push_clear_all();
    in_data = 8'h41;
    in_valid = 1'b1;
    reset = 1'b0;
    do begin
      @(negedge clk);
      n++;
      if (n > 20000) timeout("clrall_wait");
    end while (!in_ready);
    in_valid = 1'b0;
    chk("clrall_cycles", n, ROWS * COLS + 1);
    chk("clrall_drained", exp_q.size(), 0);
    chk("clrall_cursor", {cursor_row, cursor_col}, 0);
  endtask

  initial begin
    #800000;
    fails++;
    $display("FAIL watchdog: simulation exceeded time limit");
    summary_and_finish();
  end

  initial begin
    logic [7:0] b;
    int k;
    do_reset();
    send(8'h41);
    send(8'h42);
    chk("ab_col", cursor_col, 2);
    send(8'h0D);
    for (int i = 0; i < COLS; i++) send(8'h78);
    wait_low("wrap_low", COLS + 1);
    chk("wrap_pos", {cursor_row, cursor_col}, {6'd1, 8'd0});
    for (int i = 0; i < 5; i++) send(8'h61 + 8'(i));
    send(8'h08);
    chk("bs_col", cursor_col, 4);
    chk("bs_wr", wr_en, ERASE);
    send(8'h09);
    chk("tab_col", cursor_col, 8);
    send(8'h0D);
    chk("cr_col", cursor_col, 0);
    send(8'h0C);
    wait_low("ff_low", ROWS * COLS + 1);
    chk("ff_pos", {scroll_row, cursor_row, cursor_col}, 0);
    for (int i = 1; i <= 65; i++) begin
      send(8'h0A);
      wait_low("lf_low", COLS + 1);
      if (i == 63) chk("lf63", {cursor_row, scroll_row}, {6'd63, 6'd0});
      if (i == 64) chk("lf64", {cursor_row, scroll_row}, {6'd0, 6'd1});
      if (i == 65) chk("lf65", {cursor_row, scroll_row}, {6'd1, 6'd2});
    end
    for (int i = 0; i < 200; i++) begin
      k = int'($urandom_range(0, 99));
      if (k < 70) b = 8'($urandom_range(32, 126));
      else if (k < 78) b = 8'h0D;
      else if (k < 82) b = 8'h0A;
      else if (k < 90) b = 8'h08;
      else if (k < 95) b = 8'h09;
      else if (k < 98) b = 8'($urandom_range(14, 31));
      else b = 8'($urandom_range(127, 255));
      send(b);
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end
    send(8'h0A);
    repeat (40) @(negedge clk);
    chk("mid_clr_busy", in_ready, 0);
    do_reset();
    send(8'h48);
    send(8'h69);
    send(8'h0A);
    wait_low("final_lf_low", COLS + 1);
    repeat (2) @(negedge clk);
    chk("queue_empty", exp_q.size(), 0);
    summary_and_finish();
  end
endmodule
